// File: rtl/rx_fsm.sv
// rx_fsm: UART receive frame FSM with 2-FF line synchronizer, parity and stop-bit checking.
// Optional macro UART_RX_BREAK_DETECT_EN reports all-zero framing-error frames as breaks.
module rx_fsm #(
   parameter int unsigned NO_OF_DATA_BITS = 8,
   parameter string       PARITY_ENABLED  = "FALSE",
   parameter string       PARITY_TYPE     = "EVEN",
   parameter string       NO_OF_STOP_BITS = "1"
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx_serial,
   output logic       tick_start,
   input  logic       sampling_tick_middle,
   input  logic       buffer_full,
   output logic       buffer_wr_enable,
   output logic [7:0] buffer_data,
   output logic       rx_busy,
   output logic       parity_error,
   output logic       framing_error,
   output logic       overrun_error,
   output logic       break_detected
);

   localparam logic [3:0] IDLE       = 4'd0;
   localparam logic [3:0] START_BIT  = 4'd1;
   localparam logic [3:0] DATA_BITS  = 4'd2;
   localparam logic [3:0] PARITY     = 4'd3;
   localparam logic [3:0] STOP_BITS  = 4'd4;
   localparam logic [3:0] STOP_BITSX = 4'd5;
   localparam logic [3:0] WRITE      = 4'd6;
   localparam logic [3:0] WAIT_IDLE  = 4'd7;

   localparam int unsigned N        = NO_OF_DATA_BITS;
   localparam logic [2:0]  LAST_BIT = 3'(N - 1);
   localparam bit          PAR_EN   = (PARITY_ENABLED == "TRUE");
   localparam bit          PAR_ODD  = (PARITY_TYPE == "ODD");
   localparam bit          TWO_STOP = (NO_OF_STOP_BITS == "2");

   logic [3:0]   state;
   logic         sync_ff;
   logic         rx_s;
   logic         rx_prev;
   logic [N-1:0] shift_reg;
   logic [2:0]   bit_cnt;
   logic         par_acc;
   logic         perr;
   logic         ferr;
   logic         in_write;
   logic         is_break;

   assign in_write         = (state == WRITE);
   assign buffer_wr_enable = in_write && !buffer_full && !is_break;
   assign overrun_error    = in_write && buffer_full && !is_break;
   assign break_detected   = in_write && is_break;
   assign buffer_data      = 8'(shift_reg);

`ifdef UART_RX_BREAK_DETECT_EN
   // Tracks whether any data or parity sample was high during the current frame.
   logic seen_one;

   assign is_break = ferr && !seen_one;

   always_ff @(posedge clk) begin
      if (reset || state == IDLE) begin
         seen_one <= 1'b0;
      end else if (sampling_tick_middle && (state == DATA_BITS || state == PARITY)) begin
         seen_one <= seen_one | rx_s;
      end
   end
`else
   assign is_break = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         sync_ff       <= 1'b1;
         rx_s          <= 1'b1;
         rx_prev       <= 1'b1;
         shift_reg     <= '0;
         bit_cnt       <= '0;
         par_acc       <= 1'b0;
         perr          <= 1'b0;
         ferr          <= 1'b0;
         tick_start    <= 1'b0;
         rx_busy       <= 1'b0;
         parity_error  <= 1'b0;
         framing_error <= 1'b0;
      end else begin
         sync_ff <= rx_serial;
         rx_s    <= sync_ff;
         rx_prev <= rx_s;

         case (state)
            IDLE: begin
               if (!rx_s && rx_prev) begin
                  state      <= START_BIT;
                  tick_start <= 1'b1;
                  rx_busy    <= 1'b1;
                  shift_reg  <= '0;
                  bit_cnt    <= '0;
                  par_acc    <= 1'b0;
                  perr       <= 1'b0;
                  ferr       <= 1'b0;
               end
            end

            START_BIT: begin
               if (sampling_tick_middle) begin
                  if (rx_s) begin
                     state      <= IDLE;
                     tick_start <= 1'b0;
                     rx_busy    <= 1'b0;
                  end else begin
                     state <= DATA_BITS;
                  end
               end
            end

            DATA_BITS: begin
               if (sampling_tick_middle) begin
                  shift_reg <= {rx_s, shift_reg[N-1:1]};
                  par_acc   <= par_acc ^ rx_s;
                  bit_cnt   <= bit_cnt + 3'd1;
                  if (bit_cnt == LAST_BIT) begin
                     state <= PAR_EN ? PARITY : STOP_BITS;
                  end
               end
            end

            PARITY: begin
               if (sampling_tick_middle) begin
                  perr  <= PAR_ODD ? ~(par_acc ^ rx_s) : (par_acc ^ rx_s);
                  state <= STOP_BITS;
               end
            end

            STOP_BITS: begin
               if (sampling_tick_middle) begin
                  ferr <= ~rx_s;
                  if (TWO_STOP) begin
                     state <= STOP_BITSX;
                  end else begin
                     state      <= WRITE;
                     tick_start <= 1'b0;
                  end
               end
            end

            STOP_BITSX: begin
               if (sampling_tick_middle) begin
                  ferr       <= ferr | ~rx_s;
                  state      <= WRITE;
                  tick_start <= 1'b0;
               end
            end

            WRITE: begin
               parity_error  <= perr;
               framing_error <= ferr;
               if (ferr) begin
                  state <= WAIT_IDLE;
               end else begin
                  state   <= IDLE;
                  rx_busy <= 1'b0;
               end
            end

            WAIT_IDLE: begin
               // A line still held low after a bad stop bit must not look like a new start.
               if (rx_s) begin
                  state   <= IDLE;
                  rx_busy <= 1'b0;
               end
            end

            default: begin
               state      <= IDLE;
               tick_start <= 1'b0;
               rx_busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rx_fsm.sv
// tb_rx_fsm: randomized and directed frames into four rx_fsm configurations, checked
// against a frame-level reference model; a bench tick generator follows each tick_start.
module tb_rx_fsm;

   localparam int BIT = 16;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] rx_line = '1;
   logic [3:0] bfull = '0;
   logic [3:0] tick = '0;
   logic [3:0] ts, wr, busy, perr_o, ferr_o, ovr, brk;
   logic [7:0] bdata [4];

   int nb_c  [4] = '{8, 8, 8, 6};
   bit par_c [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
   bit odd_c [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
   int ns_c  [4] = '{1, 1, 2, 2};

   bit exp_pe [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
   bit exp_fe [4] = '{1'b0, 1'b0, 1'b0, 1'b0};

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   rx_fsm #(.NO_OF_DATA_BITS(8)) dut0 (
      .clk(clk), .reset(reset), .rx_serial(rx_line[0]), .tick_start(ts[0]),
      .sampling_tick_middle(tick[0]), .buffer_full(bfull[0]), .buffer_wr_enable(wr[0]),
      .buffer_data(bdata[0]), .rx_busy(busy[0]), .parity_error(perr_o[0]),
      .framing_error(ferr_o[0]), .overrun_error(ovr[0]), .break_detected(brk[0]));

   rx_fsm #(.NO_OF_DATA_BITS(8), .PARITY_ENABLED("TRUE"), .PARITY_TYPE("ODD")) dut1 (
      .clk(clk), .reset(reset), .rx_serial(rx_line[1]), .tick_start(ts[1]),
      .sampling_tick_middle(tick[1]), .buffer_full(bfull[1]), .buffer_wr_enable(wr[1]),
      .buffer_data(bdata[1]), .rx_busy(busy[1]), .parity_error(perr_o[1]),
      .framing_error(ferr_o[1]), .overrun_error(ovr[1]), .break_detected(brk[1]));

   rx_fsm #(.NO_OF_DATA_BITS(8), .NO_OF_STOP_BITS("2")) dut2 (
      .clk(clk), .reset(reset), .rx_serial(rx_line[2]), .tick_start(ts[2]),
      .sampling_tick_middle(tick[2]), .buffer_full(bfull[2]), .buffer_wr_enable(wr[2]),
      .buffer_data(bdata[2]), .rx_busy(busy[2]), .parity_error(perr_o[2]),
      .framing_error(ferr_o[2]), .overrun_error(ovr[2]), .break_detected(brk[2]));

   rx_fsm #(.NO_OF_DATA_BITS(6), .PARITY_ENABLED("TRUE"), .PARITY_TYPE("EVEN"),
            .NO_OF_STOP_BITS("2")) dut3 (
      .clk(clk), .reset(reset), .rx_serial(rx_line[3]), .tick_start(ts[3]),
      .sampling_tick_middle(tick[3]), .buffer_full(bfull[3]), .buffer_wr_enable(wr[3]),
      .buffer_data(bdata[3]), .rx_busy(busy[3]), .parity_error(perr_o[3]),
      .framing_error(ferr_o[3]), .overrun_error(ovr[3]), .break_detected(brk[3]));

   // Baud tick generator model: mid-bit pulse every BIT cycles while tick_start is high.
   int tcnt [4] = '{0, 0, 0, 0};
   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (!ts[i]) begin
            tcnt[i] <= 0;
            tick[i] <= 1'b0;
         end else begin
            tcnt[i] <= tcnt[i] + 1;
            tick[i] <= (tcnt[i] % BIT == 5);
         end
      end
   end

   // Monitor of the selected DUT, sampled on the falling edge.
   int         cyc = 0;
   int         sel = 0;
   int         last_tick = 0;
   logic [7:0] wr_q [$];
   int         lat_q [$];
   int         ovr_n = 0, brk_n = 0, busy_n = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (tick[sel]) last_tick = cyc;
      if (wr[sel]) begin
         wr_q.push_back(bdata[sel]);
         lat_q.push_back(cyc - last_tick);
      end
      if (ovr[sel]) ovr_n++;
      if (brk[sel]) brk_n++;
      if (busy[sel]) busy_n++;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   task automatic drive_frame(input int d, input logic [7:0] data, input bit pbit,
                              input logic [1:0] stops);
      bit q [$];
      q.push_back(1'b0);
      for (int i = 0; i < nb_c[d]; i++) q.push_back(data[i]);
      if (par_c[d]) q.push_back(pbit);
      q.push_back(stops[0]);
      if (ns_c[d] == 2) q.push_back(stops[1]);
      foreach (q[i]) begin
         rx_line[d] = q[i];
         repeat (BIT) @(negedge clk);
      end
   endtask

   // Frame-level reference: expected write/overrun/break and the held status bits.
   task automatic model_frame(input int d, input logic [7:0] data, input bit pbit,
                              input logic [1:0] stops, input bit bf,
                              output bit w, output bit o, output bit b);
      int ones;
      bit fe;
      ones = $countones(data) + ((par_c[d] && pbit) ? 1 : 0);
      fe = !stops[0] || (ns_c[d] == 2 && !stops[1]);
      b = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      b = fe && (data == 8'h00) && !(par_c[d] && pbit);
`endif
      w = !bf && !b;
      o = bf && !b;
      exp_pe[d] = par_c[d] && (odd_c[d] ? (ones % 2 == 0) : (ones % 2 == 1));
      exp_fe[d] = fe;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if ({ts, wr, busy, perr_o, ferr_o, ovr, brk} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got %h expected 0", {ts, wr, busy, perr_o, ferr_o, ovr, brk});
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (bdata[i] !== 8'h00) begin
            errors++;
            $display("FAIL reset_data%0d: got %h expected 00", i, bdata[i]);
         end
      end
      reset = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   task automatic test_basic();
      int n0;
      bit w, o, b;
      sel = 0; n0 = wr_q.size();
      model_frame(0, 8'hA5, 1'b0, 2'b11, 1'b0, w, o, b);
      drive_frame(0, 8'hA5, 1'b0, 2'b11);
      rx_line[0] = 1'b1;
      repeat (40) @(negedge clk);
      checks++;
      if (wr_q.size() - n0 !== 1) begin
         errors++; $display("FAIL basic_count: got %0d expected 1", wr_q.size() - n0);
      end else begin
         checks++;
         if (wr_q[n0] !== 8'hA5) begin
            errors++; $display("FAIL basic_data: got %h expected a5", wr_q[n0]);
         end
         checks++;
         if (lat_q[n0] !== 1) begin
            errors++; $display("FAIL basic_latency: got %0d expected 1", lat_q[n0]);
         end
      end
      checks++;
      if ({perr_o[0], ferr_o[0], busy[0], ts[0]} !== 4'b0000) begin
         errors++;
         $display("FAIL basic_status: got %b expected 0000", {perr_o[0], ferr_o[0], busy[0], ts[0]});
      end
   endtask

   task automatic test_framing();
      int n0;
      bit w, o, b;
      sel = 0; n0 = wr_q.size();
      model_frame(0, 8'h81, 1'b0, 2'b00, 1'b0, w, o, b);
      drive_frame(0, 8'h81, 1'b0, 2'b00);
      rx_line[0] = 1'b1;
      repeat (40) @(negedge clk);
      checks++;
      if (wr_q.size() - n0 !== 1 || wr_q[wr_q.size() - 1] !== 8'h81) begin
         errors++; $display("FAIL framing_write: got %0d writes expected 1 of 81", wr_q.size() - n0);
      end
      checks++;
      if (ferr_o[0] !== exp_fe[0]) begin
         errors++; $display("FAIL framing_flag: got %b expected %b", ferr_o[0], exp_fe[0]);
      end
   endtask

   task automatic test_glitch();
      int n0, b0;
      sel = 0; n0 = wr_q.size(); b0 = busy_n;
      rx_line[0] = 1'b0;
      repeat (2) @(negedge clk);
      rx_line[0] = 1'b1;
      repeat (40) @(negedge clk);
      checks++;
      if (busy_n == b0) begin
         errors++; $display("FAIL glitch_detect: got no rx_busy expected start detection");
      end
      checks++;
      if (wr_q.size() != n0 || ts[0] !== 1'b0 || busy[0] !== 1'b0) begin
         errors++;
         $display("FAIL glitch_abort: got writes=%0d ts=%b busy=%b expected 0 0 0",
                  wr_q.size() - n0, ts[0], busy[0]);
      end
      checks++;
      if (perr_o[0] !== exp_pe[0] || ferr_o[0] !== exp_fe[0]) begin
         errors++;
         $display("FAIL glitch_status: got %b%b expected %b%b", perr_o[0], ferr_o[0], exp_pe[0], exp_fe[0]);
      end
   endtask

   task automatic test_parity();
      int n0;
      bit w, o, b;
      sel = 1;
      for (int k = 0; k < 2; k++) begin
         n0 = wr_q.size();
         model_frame(1, 8'h03, k[0], 2'b11, 1'b0, w, o, b);
         drive_frame(1, 8'h03, k[0], 2'b11);
         rx_line[1] = 1'b1;
         repeat (40) @(negedge clk);
         checks++;
         if (wr_q.size() - n0 !== 1 || wr_q[wr_q.size() - 1] !== 8'h03) begin
            errors++; $display("FAIL parity_write%0d: got %0d writes expected 1 of 03", k, wr_q.size() - n0);
         end
         checks++;
         if (perr_o[1] !== exp_pe[1] || perr_o[1] !== (k == 0)) begin
            errors++; $display("FAIL parity_flag%0d: got %b expected %b", k, perr_o[1], exp_pe[1]);
         end
      end
   endtask

   task automatic test_two_stop();
      int n0;
      bit w, o, b;
      sel = 2; n0 = wr_q.size();
      model_frame(2, 8'h5A, 1'b0, 2'b01, 1'b0, w, o, b);
      drive_frame(2, 8'h5A, 1'b0, 2'b01);
      repeat (64) @(negedge clk);
      checks++;
      if (busy[2] !== 1'b1 || ts[2] !== 1'b0) begin
         errors++; $display("FAIL twostop_wait: got busy=%b ts=%b expected 1 0", busy[2], ts[2]);
      end
      checks++;
      if (wr_q.size() - n0 !== 1 || wr_q[wr_q.size() - 1] !== 8'h5A || ferr_o[2] !== exp_fe[2]) begin
         errors++;
         $display("FAIL twostop_write: got writes=%0d ferr=%b expected 1 of 5a ferr=%b",
                  wr_q.size() - n0, ferr_o[2], exp_fe[2]);
      end
      rx_line[2] = 1'b1;
      repeat (10) @(negedge clk);
      checks++;
      if (busy[2] !== 1'b0) begin
         errors++; $display("FAIL twostop_release: got busy=%b expected 0", busy[2]);
      end
   endtask

   task automatic test_overrun();
      int n0, o0;
      bit w, o, b;
      sel = 0; n0 = wr_q.size(); o0 = ovr_n;
      bfull[0] = 1'b1;
      model_frame(0, 8'h3C, 1'b0, 2'b11, 1'b1, w, o, b);
      drive_frame(0, 8'h3C, 1'b0, 2'b11);
      rx_line[0] = 1'b1;
      repeat (40) @(negedge clk);
      bfull[0] = 1'b0;
      checks++;
      if (ovr_n - o0 !== 1 || wr_q.size() != n0) begin
         errors++; $display("FAIL overrun_pulse: got ovr=%0d writes=%0d expected 1 0", ovr_n - o0, wr_q.size() - n0);
      end
      o0 = ovr_n;
      model_frame(0, 8'h3D, 1'b0, 2'b11, 1'b0, w, o, b);
      drive_frame(0, 8'h3D, 1'b0, 2'b11);
      rx_line[0] = 1'b1;
      repeat (40) @(negedge clk);
      checks++;
      if (ovr_n != o0 || wr_q.size() - n0 !== 1 || wr_q[wr_q.size() - 1] !== 8'h3D) begin
         errors++; $display("FAIL overrun_next: got ovr=%0d writes=%0d expected 0 1 of 3d", ovr_n - o0, wr_q.size() - n0);
      end
   endtask

   task automatic test_break();
      int n0, b0;
      bit w, o, b;
      sel = 0; n0 = wr_q.size(); b0 = brk_n;
      model_frame(0, 8'h00, 1'b0, 2'b00, 1'b0, w, o, b);
      drive_frame(0, 8'h00, 1'b0, 2'b00);
      repeat (2 * BIT) @(negedge clk);
      rx_line[0] = 1'b1;
      repeat (20) @(negedge clk);
      checks++;
      if (brk_n - b0 !== int'(b)) begin
         errors++; $display("FAIL break_pulse: got %0d expected %0d", brk_n - b0, b);
      end
      checks++;
      if (wr_q.size() - n0 !== int'(w) || ferr_o[0] !== 1'b1) begin
         errors++; $display("FAIL break_write: got writes=%0d ferr=%b expected %0d 1", wr_q.size() - n0, ferr_o[0], w);
      end
      if (w) begin
         checks++;
         if (wr_q[wr_q.size() - 1] !== 8'h00) begin
            errors++; $display("FAIL break_data: got %h expected 00", wr_q[wr_q.size() - 1]);
         end
      end
   endtask

   task automatic test_reset_mid();
      int n0;
      bit w, o, b;
      sel = 0; n0 = wr_q.size();
      rx_line[0] = 1'b0;
      repeat (BIT) @(negedge clk);
      rx_line[0] = 1'b1;
      repeat (3 * BIT) @(negedge clk);
      rx_line = '1;
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if ({ts[0], wr[0], busy[0], perr_o[0], ferr_o[0], ovr[0], brk[0]} !== 7'b0 || bdata[0] !== 8'h00) begin
         errors++;
         $display("FAIL resetmid_outputs: got %b data %h expected 0",
                  {ts[0], wr[0], busy[0], perr_o[0], ferr_o[0], ovr[0], brk[0]}, bdata[0]);
      end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin exp_pe[i] = 1'b0; exp_fe[i] = 1'b0; end
      repeat (5) @(negedge clk);
      checks++;
      if (wr_q.size() != n0) begin
         errors++; $display("FAIL resetmid_nowrite: got %0d writes expected 0", wr_q.size() - n0);
      end
      model_frame(0, 8'h11, 1'b0, 2'b11, 1'b0, w, o, b);
      drive_frame(0, 8'h11, 1'b0, 2'b11);
      rx_line[0] = 1'b1;
      repeat (40) @(negedge clk);
      checks++;
      if (wr_q.size() - n0 !== 1 || wr_q[wr_q.size() - 1] !== 8'h11 || ferr_o[0] !== 1'b0) begin
         errors++; $display("FAIL resetmid_frame: got writes=%0d ferr=%b expected 1 of 11 ferr=0", wr_q.size() - n0, ferr_o[0]);
      end
   endtask

   task automatic test_back_to_back();
      int n0;
      bit w, o, b;
      sel = 0; n0 = wr_q.size();
      model_frame(0, 8'hED, 1'b0, 2'b11, 1'b0, w, o, b);
      drive_frame(0, 8'h12, 1'b0, 2'b11);
      drive_frame(0, 8'hED, 1'b0, 2'b11);
      rx_line[0] = 1'b1;
      repeat (40) @(negedge clk);
      checks++;
      if (wr_q.size() - n0 !== 2) begin
         errors++; $display("FAIL b2b_count: got %0d expected 2", wr_q.size() - n0);
      end else begin
         checks++;
         if (wr_q[n0] !== 8'h12 || wr_q[n0 + 1] !== 8'hED) begin
            errors++; $display("FAIL b2b_data: got %h %h expected 12 ed", wr_q[n0], wr_q[n0 + 1]);
         end
         checks++;
         if (lat_q[n0] !== 1 || lat_q[n0 + 1] !== 1) begin
            errors++; $display("FAIL b2b_latency: got %0d %0d expected 1 1", lat_q[n0], lat_q[n0 + 1]);
         end
      end
   endtask

   task automatic test_random();
      int n0, o0, b0;
      bit w, o, b, pbit, bf;
      logic [7:0] data, mask;
      logic [1:0] stops;
      for (int d = 0; d < 4; d++) begin
         sel = d;
         mask = 8'((1 << nb_c[d]) - 1);
         for (int k = 0; k < 8; k++) begin
            n0 = wr_q.size(); o0 = ovr_n; b0 = brk_n;
            data  = ($urandom_range(0, 5) == 0) ? 8'h00 : (8'($urandom) & mask);
            pbit  = 1'($urandom);
            stops = {($urandom_range(0, 4) != 0), ($urandom_range(0, 4) != 0)};
            bf    = ($urandom_range(0, 3) == 0);
            bfull[d] = bf;
            model_frame(d, data, pbit, stops, bf, w, o, b);
            drive_frame(d, data, pbit, stops);
            rx_line[d] = 1'b1;
            repeat (40) @(negedge clk);
            bfull[d] = 1'b0;
            checks++;
            if (wr_q.size() - n0 !== int'(w) || ovr_n - o0 !== int'(o) || brk_n - b0 !== int'(b)) begin
               errors++;
               $display("FAIL rand_events d%0d data %h: got wr=%0d ovr=%0d brk=%0d expected %0d %0d %0d",
                        d, data, wr_q.size() - n0, ovr_n - o0, brk_n - b0, w, o, b);
            end else if (w) begin
               checks++;
               if (wr_q[n0] !== data || lat_q[n0] !== 1) begin
                  errors++;
                  $display("FAIL rand_data d%0d: got %h lat %0d expected %h lat 1", d, wr_q[n0], lat_q[n0], data);
               end
            end
            checks++;
            if (perr_o[d] !== exp_pe[d] || ferr_o[d] !== exp_fe[d] || busy[d] !== 1'b0 || ts[d] !== 1'b0) begin
               errors++;
               $display("FAIL rand_status d%0d data %h: got pe=%b fe=%b busy=%b ts=%b expected %b %b 0 0",
                        d, data, perr_o[d], ferr_o[d], busy[d], ts[d], exp_pe[d], exp_fe[d]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_framing();
      test_glitch();
      test_parity();
      test_two_stop();
      test_overrun();
      test_break();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
